// File: rtl/rename_ctrl_pkg.sv
// Shared types and defaults for the rename controller and its ROB pointers.
package rename_ctrl_pkg;
  localparam int REG_W          = 5;   // architectural register id width
  localparam int ROB_DEPTH      = 16;  // power of two
  localparam int FLUSH_WAIT_DEF = 2;

  typedef enum logic [1:0] {
    RENAME_RUN   = 2'd0,
    RENAME_FLUSH = 2'd1,
    RENAME_DRAIN = 2'd2
  } rename_state_e;
endpackage

// File: rtl/rename_ctrl_rob_ptr.sv
// Wrapping ROB pointer; clear has priority over increment.
module rob_ptr #(
  parameter int ADDR = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            clr,
  output logic [ADDR-1:0] ptr
);
  logic [ADDR-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr)      ptr_d = '0;
    else if (inc) ptr_d = ptr_q + ADDR'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/rename_ctrl.sv
// ROB tag allocator and rename-map sequencer: hands out tail tags on dispatch,
// retires at head, and drives the map write/invalidate/flush strobes.
module rename_ctrl
  import rename_ctrl_pkg::*;
#(
  parameter int DATA       = REG_W,
  parameter int DEPTH      = ROB_DEPTH,
  parameter int FLUSH_WAIT = FLUSH_WAIT_DEF,
  localparam int ADDR      = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dis_valid,
  output logic            dis_ready,
  input  logic            dis_wv,
  input  logic [DATA-1:0] dis_rd,
  output logic [ADDR-1:0] dis_tag,
  input  logic            com_valid,
  output logic [ADDR-1:0] com_tag,
  input  logic            flush_req,
  output logic            map_we_,
  output logic            map_wv,
  output logic [DATA-1:0] map_wd,
  output logic [ADDR-1:0] map_waddr,
  output logic            map_inve_,
  output logic [ADDR-1:0] map_invaddr,
  output logic            map_flush_,
  output logic            empty,
  output logic            full,
  output logic [ADDR:0]   count
);
  localparam logic [ADDR:0] FULL_CNT = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] ONE      = (ADDR+1)'(1);
  localparam logic [3:0]    WAIT_CNT = 4'(FLUSH_WAIT);

  rename_state_e   state_q, state_d;
  logic [3:0]      drain_q, drain_d;
  logic [ADDR:0]   count_q, count_d;
  logic [ADDR-1:0] head, tail;
  logic            dis_acc, com_acc, flush_go;

  rob_ptr #(.ADDR(ADDR)) u_tail (
    .clk(clk), .rst(reset), .inc(dis_acc), .clr(flush_go), .ptr(tail)
  );
  rob_ptr #(.ADDR(ADDR)) u_head (
    .clk(clk), .rst(reset), .inc(com_acc), .clr(flush_go), .ptr(head)
  );

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign count     = count_q;
  // Gated by reset so nothing is offered while the block is held in reset.
  assign dis_ready = !reset && (state_q == RENAME_RUN) && !full && !flush_req;
  assign dis_acc   = dis_valid && dis_ready;
  assign com_acc   = com_valid && !empty && (state_q == RENAME_RUN) && !flush_req;
  assign flush_go  = flush_req && (state_q != RENAME_FLUSH);

  assign dis_tag     = tail;
  assign com_tag     = head;
  assign map_we_     = !dis_acc;
  assign map_wv      = dis_wv;
  assign map_wd      = dis_rd;
  assign map_waddr   = tail;
  assign map_inve_   = !com_acc;
  assign map_invaddr = head;
  assign map_flush_  = (state_q != RENAME_FLUSH);

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    count_d = count_q;
    if (flush_go) begin
      state_d = RENAME_FLUSH;
      count_d = '0;
    end else begin
      unique case (state_q)
        RENAME_RUN: begin
          if (dis_acc && !com_acc)      count_d = count_q + ONE;
          else if (com_acc && !dis_acc) count_d = count_q - ONE;
        end
        RENAME_FLUSH: begin
          state_d = RENAME_DRAIN;
          drain_d = WAIT_CNT;
        end
        RENAME_DRAIN: begin
          // The cycle that takes the counter to zero is the last blocked one.
          drain_d = drain_q - 4'd1;
          if (drain_q <= 4'd1) begin
            state_d = RENAME_RUN;
            drain_d = '0;
          end
        end
        default: state_d = RENAME_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RENAME_RUN;
      drain_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_rename_ctrl.sv
// Directed bench for rename_ctrl: reset, dispatch, fill, full commit, wrap, flush.
module tb_rename_ctrl;
  logic       clk, reset;
  logic       dis_valid, dis_ready, dis_wv;
  logic [4:0] dis_rd;
  logic [3:0] dis_tag, com_tag, map_waddr, map_invaddr;
  logic       com_valid, flush_req;
  logic       map_we_, map_wv, map_inve_, map_flush_;
  logic [4:0] map_wd;
  logic       empty, full;
  logic [4:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  rename_ctrl dut (
    .clk(clk), .reset(reset),
    .dis_valid(dis_valid), .dis_ready(dis_ready), .dis_wv(dis_wv),
    .dis_rd(dis_rd), .dis_tag(dis_tag),
    .com_valid(com_valid), .com_tag(com_tag), .flush_req(flush_req),
    .map_we_(map_we_), .map_wv(map_wv), .map_wd(map_wd), .map_waddr(map_waddr),
    .map_inve_(map_inve_), .map_invaddr(map_invaddr), .map_flush_(map_flush_),
    .empty(empty), .full(full), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled mid-low-phase.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; dis_valid = 0; dis_wv = 0; dis_rd = '0; com_valid = 0; flush_req = 0;
    repeat (3) step();
    n_cmp++; if (dis_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_held got=%b exp=0", dis_ready); end
    reset = 1'b0;
    #1;
    n_cmp++; if (dis_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%b exp=1", dis_ready); end
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL rst_empty_full got=%b%b exp=10", empty, full); end
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    n_cmp++; if (dis_tag !== 4'd0 || com_tag !== 4'd0) begin n_bad++; $display("FAIL rst_tags got=%0d/%0d exp=0/0", dis_tag, com_tag); end
    n_cmp++; if ({map_we_, map_inve_, map_flush_} !== 3'b111) begin n_bad++; $display("FAIL rst_strobes got=%b exp=111", {map_we_, map_inve_, map_flush_}); end
  endtask

  task automatic test_dispatch();
    for (int i = 0; i < 3; i++) begin
      dis_valid = 1; dis_wv = 1; dis_rd = 5'(5 + 2*i);
      #1;
      n_cmp++; if (dis_tag !== 4'(i)) begin n_bad++; $display("FAIL dis_tag[%0d] got=%0d exp=%0d", i, dis_tag, i); end
      n_cmp++; if (map_we_ !== 1'b0 || map_waddr !== 4'(i) || map_wd !== 5'(5 + 2*i) || map_wv !== 1'b1) begin
        n_bad++; $display("FAIL dis_map[%0d] got we_=%b a=%0d d=%0d wv=%b exp 0/%0d/%0d/1", i, map_we_, map_waddr, map_wd, map_wv, i, 5 + 2*i);
      end
      step();
    end
    dis_valid = 0; #1;
    n_cmp++; if (count !== 5'd3 || map_we_ !== 1'b1) begin n_bad++; $display("FAIL dis_count got=%0d we_=%b exp=3/1", count, map_we_); end
  endtask

  task automatic test_fill();
    for (int i = 3; i < 16; i++) begin
      dis_valid = 1; dis_rd = 5'(i);
      step();
    end
    n_cmp++; if (full !== 1'b1 || dis_ready !== 1'b0 || count !== 5'd16) begin
      n_bad++; $display("FAIL fill_full got full=%b rdy=%b cnt=%0d exp 1/0/16", full, dis_ready, count);
    end
    n_cmp++; if (map_we_ !== 1'b1) begin n_bad++; $display("FAIL fill_reject got we_=%b exp=1", map_we_); end
    step();
    dis_valid = 0; #1;
    n_cmp++; if (dis_tag !== 4'd0 || count !== 5'd16) begin n_bad++; $display("FAIL fill_hold got tag=%0d cnt=%0d exp 0/16", dis_tag, count); end
  endtask

  task automatic test_full_commit();
    dis_valid = 1; com_valid = 1; #1;
    n_cmp++; if (map_inve_ !== 1'b0 || map_invaddr !== 4'd0 || map_we_ !== 1'b1) begin
      n_bad++; $display("FAIL fc_same got inve_=%b ia=%0d we_=%b exp 0/0/1", map_inve_, map_invaddr, map_we_);
    end
    step();
    com_valid = 0; #1;
    n_cmp++; if (count !== 5'd15 || com_tag !== 4'd1) begin n_bad++; $display("FAIL fc_count got=%0d head=%0d exp 15/1", count, com_tag); end
    n_cmp++; if (map_we_ !== 1'b0 || dis_tag !== 4'd0) begin n_bad++; $display("FAIL fc_redispatch got we_=%b tag=%0d exp 0/0", map_we_, dis_tag); end
    step();
    dis_valid = 0; #1;
    n_cmp++; if (count !== 5'd16 || dis_tag !== 4'd1) begin n_bad++; $display("FAIL fc_refill got cnt=%0d tail=%0d exp 16/1", count, dis_tag); end
  endtask

  task automatic test_wrap();
    // Drain fully (head 1 -> 1), then step both pointers to 14.
    com_valid = 1; repeat (16) step();
    com_valid = 0; #1;
    n_cmp++; if (empty !== 1'b1 || com_tag !== 4'd1) begin n_bad++; $display("FAIL wrap_drain got empty=%b head=%0d exp 1/1", empty, com_tag); end
    com_valid = 1; #1;
    n_cmp++; if (map_inve_ !== 1'b1) begin n_bad++; $display("FAIL wrap_empty_commit got inve_=%b exp=1", map_inve_); end
    step();
    com_valid = 0;
    dis_valid = 1; repeat (13) step();
    dis_valid = 0; com_valid = 1; repeat (13) step();
    com_valid = 0; #1;
    n_cmp++; if (dis_tag !== 4'd14 || com_tag !== 4'd14 || empty !== 1'b1) begin
      n_bad++; $display("FAIL wrap_setup got tail=%0d head=%0d empty=%b exp 14/14/1", dis_tag, com_tag, empty);
    end
    for (int i = 0; i < 4; i++) begin
      dis_valid = 1; #1;
      n_cmp++; if (dis_tag !== 4'((14 + i) % 16) || map_we_ !== 1'b0) begin
        n_bad++; $display("FAIL wrap_dis[%0d] got tag=%0d we_=%b exp %0d/0", i, dis_tag, map_we_, (14 + i) % 16);
      end
      step();
    end
    dis_valid = 0;
    for (int i = 0; i < 4; i++) begin
      com_valid = 1; #1;
      n_cmp++; if (com_tag !== 4'((14 + i) % 16) || map_invaddr !== 4'((14 + i) % 16) || map_inve_ !== 1'b0) begin
        n_bad++; $display("FAIL wrap_com[%0d] got tag=%0d ia=%0d inve_=%b exp %0d/%0d/0", i, com_tag, map_invaddr, map_inve_, (14 + i) % 16, (14 + i) % 16);
      end
      step();
    end
    com_valid = 0; #1;
    n_cmp++; if (empty !== 1'b1 || count !== 5'd0) begin n_bad++; $display("FAIL wrap_empty got empty=%b cnt=%0d exp 1/0", empty, count); end
  endtask

  task automatic test_flush();
    dis_valid = 1; repeat (5) step();
    dis_valid = 0; #1;
    n_cmp++; if (count !== 5'd5) begin n_bad++; $display("FAIL fl_setup got cnt=%0d exp=5", count); end
    dis_valid = 1; com_valid = 1; flush_req = 1; #1;
    n_cmp++; if (map_we_ !== 1'b1 || map_inve_ !== 1'b1 || dis_ready !== 1'b0) begin
      n_bad++; $display("FAIL fl_override got we_=%b inve_=%b rdy=%b exp 1/1/0", map_we_, map_inve_, dis_ready);
    end
    step();
    // Held into FLUSH: must be ignored, not restart.
    dis_valid = 0; com_valid = 0; #1;
    n_cmp++; if (map_flush_ !== 1'b0 || dis_ready !== 1'b0 || count !== 5'd0 || dis_tag !== 4'd0 || com_tag !== 4'd0) begin
      n_bad++; $display("FAIL fl_flush got fl_=%b rdy=%b cnt=%0d tail=%0d head=%0d exp 0/0/0/0/0", map_flush_, dis_ready, count, dis_tag, com_tag);
    end
    step();
    flush_req = 0; #1;
    n_cmp++; if (map_flush_ !== 1'b1 || dis_ready !== 1'b0) begin n_bad++; $display("FAIL fl_drain1 got fl_=%b rdy=%b exp 1/0", map_flush_, dis_ready); end
    step();
    n_cmp++; if (dis_ready !== 1'b0) begin n_bad++; $display("FAIL fl_drain2 got rdy=%b exp=0", dis_ready); end
    step();
    n_cmp++; if (dis_ready !== 1'b1 || dis_tag !== 4'd0 || count !== 5'd0) begin
      n_bad++; $display("FAIL fl_resume got rdy=%b tag=%0d cnt=%0d exp 1/0/0", dis_ready, dis_tag, count);
    end
    // Restart from inside DRAIN.
    dis_valid = 1; repeat (2) step();
    dis_valid = 0; flush_req = 1; step();
    flush_req = 0; step();
    flush_req = 1; #1;
    n_cmp++; if (map_flush_ !== 1'b1 || dis_ready !== 1'b0) begin n_bad++; $display("FAIL fl_in_drain got fl_=%b rdy=%b exp 1/0", map_flush_, dis_ready); end
    step();
    flush_req = 0; #1;
    n_cmp++; if (map_flush_ !== 1'b0) begin n_bad++; $display("FAIL fl_restart got fl_=%b exp=0", map_flush_); end
    step(); step();
    n_cmp++; if (dis_ready !== 1'b0) begin n_bad++; $display("FAIL fl_restart_drain got rdy=%b exp=0", dis_ready); end
    step();
    n_cmp++; if (dis_ready !== 1'b1 || count !== 5'd0) begin n_bad++; $display("FAIL fl_restart_done got rdy=%b cnt=%0d exp 1/0", dis_ready, count); end
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_fill();
    test_full_commit();
    test_wrap();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
